// File: rtl/sim_harness_ctrl.sv
// Run controller for the pipeline_rv32i core.
// Sequences the core reset, counts run cycles and retired instructions,
// watches the tohost mailbox for pass/fail writes and enforces a watchdog.
module sim_harness_ctrl #(
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 90,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_0FFC),
  parameter int unsigned NUM_RETIRE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [NUM_RETIRE-1:0] retire_valid,
  output logic                  core_rst,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [DATA_W-2:0]     exit_code,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      retire_count,
  output logic [2:0]            state
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned POP_W  = $clog2(NUM_RETIRE + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [63:0]       WD_LAST   = 64'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]    r_cycle;
  logic [CNT_W-1:0]    r_retire;
  logic [DATA_W-2:0]   r_exit;
  logic                r_core_rst;
  logic                r_done;
  logic                r_pass;
  logic                r_fail;
  logic                r_timeout;

  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   w_hold_cnt_nxt;
  logic [CNT_W-1:0]    w_cycle_nxt;
  logic [CNT_W-1:0]    w_retire_nxt;
  logic [DATA_W-2:0]   w_exit_nxt;
  logic [POP_W-1:0]    w_pop;
  logic [SUM_W-1:0]    w_ret_sum;
  logic                w_halt;
  logic                w_wd_hit;

  // Retire popcount, saturating retire sum, halt and watchdog detection
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(NUM_RETIRE); i++) begin
      w_pop = w_pop + POP_W'(retire_valid[i]);
    end
    w_ret_sum = {1'b0, r_retire} + SUM_W'(w_pop);
    w_halt    = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    w_wd_hit  = (64'(r_cycle) == WD_LAST);
  end

  // Next-state and next-value logic
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_cycle_nxt    = r_cycle;
    w_retire_nxt   = r_retire;
    w_exit_nxt     = r_exit;
    case (r_state)
      ST_HOLD: begin
        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cycle != {CNT_W{1'b1}}) begin
          w_cycle_nxt = r_cycle + CNT_W'(1);
        end
        if (w_ret_sum[CNT_W]) begin
          w_retire_nxt = {CNT_W{1'b1}};
        end else begin
          w_retire_nxt = w_ret_sum[CNT_W-1:0];
        end
        if (w_halt) begin
          if (mem_wdata == DATA_W'(1)) begin
            w_state_nxt = ST_PASS;
            w_exit_nxt  = '0;
          end else begin
            w_state_nxt = ST_FAIL;
            w_exit_nxt  = mem_wdata[DATA_W-1:1];
          end
        end else if (w_wd_hit) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  // State, counters and decoded flags; everything returns to HOLD on rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= '0;
      r_cycle    <= '0;
      r_retire   <= '0;
      r_exit     <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_cycle    <= w_cycle_nxt;
      r_retire   <= w_retire_nxt;
      r_exit     <= w_exit_nxt;
      r_core_rst <= (w_state_nxt != ST_RUN);
      r_done     <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL) ||
                    (w_state_nxt == ST_TIMEOUT);
      r_pass     <= (w_state_nxt == ST_PASS);
      r_fail     <= (w_state_nxt == ST_FAIL);
      r_timeout  <= (w_state_nxt == ST_TIMEOUT);
    end
  end

  assign core_rst     = r_core_rst;
  assign done         = r_done;
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign timeout      = r_timeout;
  assign exit_code    = r_exit;
  assign cycle_count  = r_cycle;
  assign retire_count = r_retire;
  assign state        = r_state;

endmodule
